// File: rtl/fp_add_pkg.sv
// Shared types and constants for the fp16 adder scheduler.
package fp_add_pkg;

    localparam int FP16_W      = 16;
    localparam int ADD_LAT_DEF = 2;

    typedef logic [FP16_W-1:0] fp16_t;

    // Tag width for n requesters; never narrower than one bit.
    function automatic int tag_w(input int n);
        if (n <= 32'sd2) begin
            return 32'sd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/fp_sched_arb.sv
// Eligible-mask to one-hot grant. With FP_ADD_SCHED_RR_EN defined the search
// rotates from a pointer register; otherwise lowest index wins.
module fp_sched_arb
    import fp_add_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = tag_w(NUM_REQ)
)(
    input  logic               clk,
    input  logic               nrst,
    input  logic [NUM_REQ-1:0] elig,
    output logic [NUM_REQ-1:0] grant,
    output logic [TAG_W-1:0]   grant_idx,
    output logic               grant_vld
);

    assign grant_vld = |elig;

`ifdef FP_ADD_SCHED_RR_EN
    logic [TAG_W-1:0] ptr_r;

    // Rotating search; scanning high-to-low leaves the closest hit to the pointer
    always_comb begin
        grant_idx = '0;
        for (int k = NUM_REQ - 32'sd1; k >= 32'sd0; k--) begin
            int j;
            j = (int'(ptr_r) + k) % NUM_REQ;
            if (elig[TAG_W'(j)]) begin
                grant_idx = TAG_W'(j);
            end else begin
                grant_idx = grant_idx;
            end
        end
    end

    // Pointer moves past the winner only when a grant is taken
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ptr_r <= '0;
        end else if (grant_vld) begin
            ptr_r <= TAG_W'((int'(grant_idx) + 32'sd1) % NUM_REQ);
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    logic unused_s;
    assign unused_s = clk & nrst;

    // Fixed priority; scanning high-to-low leaves the lowest eligible index
    always_comb begin
        grant_idx = '0;
        for (int k = NUM_REQ - 32'sd1; k >= 32'sd0; k--) begin
            if (elig[TAG_W'(k)]) begin
                grant_idx = TAG_W'(k);
            end else begin
                grant_idx = grant_idx;
            end
        end
    end
`endif

    // One-hot expansion of the winning index
    always_comb begin
        grant = '0;
        if (grant_vld) begin
            grant[grant_idx] = 1'b1;
        end else begin
            grant = '0;
        end
    end

endmodule

// File: rtl/fp_add_sched.sv
// Shares one pipelined fp16 adder among NUM_REQ requesters and routes each sum
// back by tag. Build option: FP_ADD_SCHED_RR_EN selects round-robin arbitration.
module fp_add_sched
    import fp_add_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADD_LAT = ADD_LAT_DEF
)(
    input  logic                      clk,
    input  logic                      nrst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*FP16_W-1:0] req_a,
    input  logic [NUM_REQ*FP16_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [FP16_W-1:0]         resp_data,
    output logic                      add_en,
    output logic [FP16_W-1:0]         add_a,
    output logic [FP16_W-1:0]         add_b,
    input  logic [FP16_W-1:0]         add_out
);

    localparam int TAG_W = tag_w(NUM_REQ);

    logic [NUM_REQ-1:0] busy_r;
    logic [NUM_REQ-1:0] elig_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [TAG_W-1:0]   grant_idx_s;
    logic               grant_vld_s;
    fp16_t              a_arr_s [NUM_REQ];
    fp16_t              b_arr_s [NUM_REQ];
    logic [ADD_LAT:0]   tag_vld_r;
    logic [TAG_W-1:0]   tag_r [ADD_LAT+1];
    logic               rel_vld_s;
    logic [TAG_W-1:0]   rel_tag_s;
    logic [NUM_REQ-1:0] rel_mask_s;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign a_arr_s[g] = req_a[g*FP16_W +: FP16_W];
        assign b_arr_s[g] = req_b[g*FP16_W +: FP16_W];
    end

    assign elig_s = req_valid & ~busy_r;

    fp_sched_arb #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_arb (
        .clk       (clk),
        .nrst      (nrst),
        .elig      (elig_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_vld (grant_vld_s)
    );

    // Grant is a handshake, so it must vanish the instant reset asserts
    assign req_ready = grant_s & {NUM_REQ{nrst}};

    assign rel_vld_s = tag_vld_r[ADD_LAT];
    assign rel_tag_s = tag_r[ADD_LAT];

    // Requester whose result is leaving the adder this cycle
    always_comb begin
        rel_mask_s = '0;
        if (rel_vld_s) begin
            rel_mask_s[rel_tag_s] = 1'b1;
        end else begin
            rel_mask_s = '0;
        end
    end

    // Busy tracking: set on grant, cleared as the response is registered
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            busy_r <= '0;
        end else begin
            busy_r <= (busy_r & ~rel_mask_s) | grant_s;
        end
    end

    // Tag pipeline: one slot per cycle, bubbles carry a cleared valid bit
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tag_vld_r <= '0;
            for (int k = 0; k <= ADD_LAT; k++) begin
                tag_r[k] <= '0;
            end
        end else begin
            tag_vld_r <= {tag_vld_r[ADD_LAT-1:0], grant_vld_s};
            tag_r[0]  <= grant_idx_s;
            for (int k = 1; k <= ADD_LAT; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
        end
    end

    // Adder drive: operands are zeroed in idle cycles
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            add_en <= 1'b0;
            add_a  <= '0;
            add_b  <= '0;
        end else if (grant_vld_s) begin
            add_en <= 1'b1;
            add_a  <= a_arr_s[grant_idx_s];
            add_b  <= b_arr_s[grant_idx_s];
        end else begin
            add_en <= 1'b0;
            add_a  <= '0;
            add_b  <= '0;
        end
    end

    // Response: one-cycle pulse to the tagged requester with the adder result
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            resp_valid <= '0;
            resp_data  <= '0;
        end else if (rel_vld_s) begin
            resp_valid <= rel_mask_s;
            resp_data  <= add_out;
        end else begin
            resp_valid <= '0;
            resp_data  <= '0;
        end
    end

endmodule

// File: tb/tb_fp_add_sched.sv
// Scoreboard bench for fp_add_sched with a behavioural fp16 adder and a
// cycle-level requester/arbitration reference model.
module tb_fp_add_sched;
    import fp_add_pkg::*;

    localparam int N   = 4;
    localparam int LAT = ADD_LAT_DEF;

    logic              clk = 1'b0;
    logic              nrst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*16-1:0]   req_a;
    logic [N*16-1:0]   req_b;
    logic [N-1:0]      resp_valid;
    logic [15:0]       resp_data;
    logic              add_en;
    logic [15:0]       add_a;
    logic [15:0]       add_b;
    logic [15:0]       add_out;

    always #5 clk = ~clk;

    fp_add_sched #(.NUM_REQ(N), .ADD_LAT(LAT)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .add_en     (add_en),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_out    (add_out)
    );

    // fp16 helpers, valid for non-negative integers below 2048
    function automatic logic [15:0] enc(input int v);
        int e;
        int m;
        if (v == 0) return 16'h0000;
        e = 0;
        for (int k = 0; k < 12; k++) if (v >= (1 << k)) e = k;
        m = (e <= 10) ? ((v << (10 - e)) & 1023) : ((v >> (e - 10)) & 1023);
        return {1'b0, 5'(e + 15), 10'(m)};
    endfunction

    function automatic int dec(input logic [15:0] h);
        int e;
        int m;
        if (h[14:0] == 15'h0000) return 0;
        e = int'(h[14:10]) - 15;
        m = int'({1'b1, h[9:0]});
        return (e >= 10) ? (m << (e - 10)) : (m >> (10 - e));
    endfunction

    // Behavioural adder with LAT register stages
    logic [15:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= add_en ? enc(dec(add_a) + dec(add_b)) : 16'h0000;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign add_out = pipe[LAT-1];

    typedef struct {
        int          tag;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [N-1:0] pend;
    logic [15:0] pa [N];
    logic [15:0] pb [N];
    logic [15:0] pexp [N];
    int          rel [N];
    int          last_g;
    logic        exp_en;
    logic [15:0] exp_a;
    logic [15:0] exp_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [N-1:0] exp_grant(input logic [N-1:0] el);
        logic [N-1:0] g;
        g = '0;
`ifdef FP_ADD_SCHED_RR_EN
        for (int k = N - 1; k >= 0; k--) if (el[(last_g + 1 + k) % N]) begin
            g = '0;
            g[(last_g + 1 + k) % N] = 1'b1;
        end
`else
        for (int j = N - 1; j >= 0; j--) if (el[j]) begin
            g = '0;
            g[j] = 1'b1;
        end
`endif
        return g;
    endfunction

    // Monitor: every cycle either the head response is due or the bus is idle
    always @(negedge clk) begin
        if (nrst) begin
            if (q.size() > 0 && q[0].cyc == cyc) begin
                logic [N-1:0] m;
                m = '0;
                m[q[0].tag] = 1'b1;
                check("resp_valid", 32'(resp_valid), 32'(m));
                check("resp_data", 32'(resp_data), 32'(q[0].data));
                void'(q.pop_front());
            end else begin
                check("resp_idle", 32'(resp_valid), 32'(0));
            end
        end
    end

    task automatic req(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
        pend[i] = 1'b1;
        pa[i]   = a;
        pb[i]   = b;
        pexp[i] = e;
    endtask

    task automatic step();
        logic [N-1:0] el;
        logic [N-1:0] g;
        logic [N-1:0] hs;
        @(negedge clk);
        check("add_en", 32'(add_en), 32'(exp_en));
        check("add_a", 32'(add_a), 32'(exp_a));
        check("add_b", 32'(add_b), 32'(exp_b));
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = pend[i];
            req_a[16*i +: 16]  = pa[i];
            req_b[16*i +: 16]  = pb[i];
        end
        #1;
        for (int i = 0; i < N; i++) el[i] = pend[i] && (cyc >= rel[i]);
        g = exp_grant(el);
        check("req_ready", 32'(req_ready), 32'(g));
        hs = req_valid & req_ready;
        exp_en = 1'b0;
        exp_a  = 16'h0000;
        exp_b  = 16'h0000;
        for (int i = 0; i < N; i++) if (hs[i]) begin
            q.push_back('{i, pexp[i], cyc + LAT + 2});
            rel[i]  = cyc + LAT + 2;
            pend[i] = 1'b0;
            last_g  = i;
            exp_en  = 1'b1;
            exp_a   = pa[i];
            exp_b   = pb[i];
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((pend != '0 || q.size() != 0) && t < 60) begin
            step();
            t++;
        end
        check("drain_pending", 32'(pend), 32'(0));
        check("drain_queue", 32'(q.size()), 32'(0));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        nrst      = 1'b0;
        req_valid = '1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'(0));
        check("rst_resp_valid", 32'(resp_valid), 32'(0));
        check("rst_resp_data", 32'(resp_data), 32'(0));
        check("rst_add_en", 32'(add_en), 32'(0));
        check("rst_add_a", 32'(add_a), 32'(0));
        check("rst_add_b", 32'(add_b), 32'(0));
        q.delete();
        pend   = '0;
        last_g = N - 1;
        exp_en = 1'b0;
        exp_a  = 16'h0000;
        exp_b  = 16'h0000;
        for (int i = 0; i < N; i++) rel[i] = 0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_ready_hold", 32'(req_ready), 32'(0));
        @(negedge clk);
        req_valid = '0;
        nrst      = 1'b1;
    endtask

    initial begin
        int t0;
        int ia;
        int ib;
        nrst      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        pend      = '0;
        for (int i = 0; i < N; i++) begin
            pa[i] = 16'h0000; pb[i] = 16'h0000; pexp[i] = 16'h0000; rel[i] = 0;
        end
        reset_dut();

        // single operation: 1.0 + 2.0
        req(0, 16'h3C00, 16'h4000, 16'h4200);
        drain();

        // busy block: re-request immediately after the handshake
        req(0, 16'h4000, 16'h4000, 16'h4400);
        step();
        t0 = cyc;
        req(0, 16'h3C00, 16'h3C00, 16'h4000);
        for (int k = 0; k < 20 && pend[0]; k++) step();
        check("busy_regrant_gap", 32'(cyc - t0), 32'(LAT + 2));
        drain();

        // contention on all four, including zero operands
        req(0, 16'h0000, 16'h4000, 16'h4000);
        req(1, 16'h3C00, 16'h0000, 16'h3C00);
        req(2, 16'h4200, 16'h3C00, 16'h4400);
        req(3, 16'h0000, 16'h0000, 16'h0000);
        drain();

        // two-way contention
        req(1, 16'h4000, 16'h3C00, 16'h4200);
        req(3, 16'h3C00, 16'h3C00, 16'h4000);
        drain();

        // randomized traffic
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(0, 1) == 1) begin
                ia = int'($urandom_range(0, 1023));
                ib = int'($urandom_range(0, 1023));
                req(i, enc(ia), enc(ib), enc(ia + ib));
            end
            step();
        end
        drain();

        // reset one cycle after a handshake: in-flight result must be dropped
        req(2, 16'h4000, 16'h4200, 16'h4500);
        step();
        step();
        reset_dut();
        repeat (LAT + 4) step();

        // post-reset single operation
        req(0, 16'h3C00, 16'h4000, 16'h4200);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/fp_add_sched.md
# fp_add_sched

Schedules a single shared half-precision adder (`half_add`) among `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The scheduler arbitrates, drives the adder's enable and operand inputs, and tracks each in-flight operation by requester tag. It returns the sum to the originating requester as a one-cycle response pulse. It sits between the compute-lane front ends and the adder instance, and issues at most one operation per cycle.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADD_LAT`, 2: adder latency in cycles, ≥1. Measured from the edge at which the adder samples `add_en`/`add_a`/`add_b` to the edge at which `add_out` is valid.
- `clk` in 1: single clock, rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: request present, per requester.
- `req_ready` out NUM_REQ: grant; handshake when `req_valid[i] & req_ready[i]` at a rising edge.
- `req_a` in NUM_REQ*16: operand A, fp16; requester i occupies bits [16i+15:16i].
- `req_b` in NUM_REQ*16: operand B, same packing.
- `resp_valid` out NUM_REQ: one-hot, one-cycle result pulse.
- `resp_data` out 16: fp16 sum, shared by all requesters; meaningful only while `resp_valid` is nonzero.
- `add_en` out 1: adder enable.
- `add_a`, `add_b` out 16: adder operands.
- `add_out` in 16: adder result.

## Operation
- Each requester has one `busy` bit, meaning at most one operation is outstanding per requester.
- Arbitration is combinational: eligible = `req_valid & ~busy`. `req_ready` is one-hot or zero and selects exactly one eligible requester.
- On handshake:
  - set `busy[i]`;
  - register `add_en`=1 and the selected `req_a`/`req_b`;
  - push tag i with a valid bit into an `ADD_LAT`+1 deep tag shift register.
- No handshake that cycle: `add_en`=0 and `add_a`/`add_b`=0 next cycle; a tag bubble is pushed.
- Tag exits the shift register with valid set:
  - register `resp_data`=`add_out`;
  - set `resp_valid`=one-hot(tag);
  - clear `busy[tag]` at the same edge.
- The requester must hold `req_valid`/`req_a`/`req_b` stable until the handshake.
- `req_ready[i]` may be high in the same cycle that `resp_valid[i]` is high, allowing back-to-back reuse.
- Responses have no backpressure. Requesters must always accept them.
- Arithmetic: operands pass through unmodified. Rounding and special values are the adder's responsibility.

## Timing
- Handshake at edge E0.
- `add_en`/operands valid during cycle E0..E1; the adder samples them at E1.
- `add_out` is sampled at E(1+`ADD_LAT`).
- `resp_valid`/`resp_data` are valid during the cycle after that edge and seen by the requester at E(2+`ADD_LAT`). With the default `ADD_LAT`, the response is seen at E4.
- Per-requester issue interval ≥ `ADD_LAT`+2 cycles. Aggregate throughput is one operation per cycle.
- Reset values:
  - `req_ready`, `resp_valid` = 0;
  - `resp_data`, `add_a`, `add_b` = 0;
  - `add_en` = 0;
  - all busy and tag-valid bits = 0;
  - round-robin pointer = 0.
- Reset mid-operation: in-flight tags are discarded and no response is produced for them. `req_ready` is driven 0 while `nrst` is low.
- Simultaneous release and request from the same requester: the release wins first, then the requester is eligible in the same cycle.

## Configuration
- `FP_ADD_SCHED_RR_EN` defined:
  - round-robin arbitration;
  - the search starts at (last granted index + 1) mod `NUM_REQ`;
  - the pointer updates only on handshake.
- Undefined: fixed priority, lowest index wins, and there is no pointer register.

## Structure
- Package `fp_add_pkg`:
  - `FP16_W`=16;
  - `typedef logic [FP16_W-1:0] fp16_t`;
  - default `ADD_LAT` constant;
  - tag width function clog2(`NUM_REQ`).
- Sub-module `fp_sched_arb` holds the eligible-mask to one-hot grant logic and, under the macro, the round-robin pointer register. It takes `clk`/`nrst`.

## Test plan
- Single operation: req0 with a=0x3C00, b=0x4000 (1.0 + 2.0), handshake at E0 → `add_en` pulses once, `resp_valid`=0001, `resp_data`=0x4200 seen at E4.
- Busy block: req0 holds `req_valid` after its handshake → `req_ready[0]`=0 until its `resp_valid` cycle, then it re-grants in that same cycle.
- Contention with the macro defined: all four requesters are valid at once → grants 0, 1, 2, 3 on consecutive edges; responses arrive on four consecutive cycles in the same order; sums are correct (for example 0x0000 + 0x4000 → 0x4000).
- Contention without the macro: req1 and req3 are valid together → req1 is granted first, req3 one cycle later.
- Reset mid-flight: assert `nrst` low one cycle after a handshake → all outputs are 0 immediately, no `resp_valid` appears afterwards, and the next request behaves as the single-operation case.
- Zero operand: a=0x3C00, b=0x0000 → `resp_data`=0x3C00 at the required latency.
